// File: rtl/dut_ctrl_pkg.sv
// Shared types and helpers for the ALU operation arbiter.
// Keeps the FSM encoding and default widths in one place.
package dut_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned RES_W  = 16;

  // Index width for n items; never zero so single-entry vectors still get a bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping
// modulo NUM_REQ. Produces a one-hot grant plus its index.
module rr_arbiter #(
  parameter int unsigned  NUM_REQ = 4,
  localparam int unsigned IW      = dut_ctrl_pkg::idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx,
  output logic               any_req
);
  import dut_ctrl_pkg::*;

  // One extra bit so ptr + k cannot overflow before the wrap.
  logic [IW:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IW + 1)'(k);
      if (cand >= (IW + 1)'(NUM_REQ)) begin
        cand = cand - (IW + 1)'(NUM_REQ);
      end
      if (!any_req && req[cand[IW-1:0]]) begin
        any_req              = 1'b1;
        gnt[cand[IW-1:0]]    = 1'b1;
        gnt_idx              = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/dut_op_arbiter.sv
// Shares one ALU among NUM_REQ requesters: round-robin accept, fixed-latency wait,
// then a held response to the granted requester. One operation in flight at a time.
module dut_op_arbiter #(
  parameter int unsigned  NUM_REQ = 4,
  parameter int unsigned  ALU_LAT = 1,
  parameter int unsigned  DATA_W  = dut_ctrl_pkg::DATA_W,
  parameter int unsigned  RES_W   = dut_ctrl_pkg::RES_W,
  localparam int unsigned IW      = dut_ctrl_pkg::idx_w(NUM_REQ),
  localparam int unsigned CW      = dut_ctrl_pkg::idx_w(ALU_LAT + 1)
) (
  input  logic                        clk,
  input  logic                        i_reset,
  input  logic [NUM_REQ-1:0]          i_req_valid,
  output logic [NUM_REQ-1:0]          o_req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   i_req_data_A,
  input  logic [NUM_REQ*DATA_W-1:0]   i_req_data_B,
  input  logic [NUM_REQ-1:0]          i_req_sel_op,
  output logic [NUM_REQ-1:0]          o_rsp_valid,
  input  logic [NUM_REQ-1:0]          i_rsp_ready,
  output logic [RES_W-1:0]            o_rsp_data,
  output logic [DATA_W-1:0]           o_alu_data_A,
  output logic [DATA_W-1:0]           o_alu_data_B,
  output logic                        o_alu_sel_op,
  input  logic [RES_W-1:0]            i_alu_data,
  output logic                        o_busy,
  output logic [IW-1:0]               o_gnt_id
);
  import dut_ctrl_pkg::*;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [IW-1:0]       ptr_q;
  logic [IW-1:0]       gnt_id_q;
  logic [DATA_W-1:0]   alu_a_q;
  logic [DATA_W-1:0]   alu_b_q;
  logic                alu_sel_q;
  logic [RES_W-1:0]    rsp_data_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;
  logic [IW-1:0]       ptr_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req     (i_req_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any_req (arb_any)
  );

  // The pointer advances past the served requester only on completion.
  assign ptr_next = (gnt_id_q == IW'(NUM_REQ - 1)) ? '0 : gnt_id_q + IW'(1);

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (arb_any) state_d = StWait;
      StWait: if (cnt_q == CW'(1)) state_d = StResp;
      StResp: if (i_rsp_ready[gnt_id_q]) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_req_ready = '0;
    o_busy      = 1'b0;
    unique case (state_q)
      StIdle: o_req_ready = arb_gnt;
      StWait: o_busy = 1'b1;
      StResp: o_busy = 1'b1;
      default: o_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      cnt_q       <= '0;
      ptr_q       <= '0;
      gnt_id_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arb_any) begin
            alu_a_q   <= i_req_data_A[arb_idx*DATA_W +: DATA_W];
            alu_b_q   <= i_req_data_B[arb_idx*DATA_W +: DATA_W];
            alu_sel_q <= i_req_sel_op[arb_idx];
            gnt_id_q  <= arb_idx;
            cnt_q     <= CW'(ALU_LAT);
          end
        end
        StWait: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            rsp_data_q  <= i_alu_data;
            rsp_valid_q <= {{(NUM_REQ - 1){1'b0}}, 1'b1} << gnt_id_q;
          end
        end
        StResp: begin
          if (i_rsp_ready[gnt_id_q]) begin
            rsp_valid_q <= '0;
            ptr_q       <= ptr_next;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_data   = rsp_data_q;
  assign o_alu_data_A = alu_a_q;
  assign o_alu_data_B = alu_b_q;
  assign o_alu_sel_op = alu_sel_q;
  assign o_gnt_id     = gnt_id_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (!i_reset)
    $onehot0(o_req_ready));
  a_rsp_onehot: assert property (@(posedge clk) disable iff (!i_reset)
    $onehot0(o_rsp_valid));

endmodule
